// File: rtl/ps2_matrix_kbd.sv
// PS/2 keyboard front end emulating an 8x8 key matrix plus SS/US/RUS modifiers for the PPI scanner.
// Latency: raw ps2_clk edge -> filtered edge 2+FILTER clk; stop-bit fall T -> code_stb/err at T+1, matrix at T+2.
// Backpressure: none; PS/2 is never held off, bytes are decoded as they arrive and col_n/mod_n are combinational.
//
// Ports:
//   clk, reset_n      system clock, async active-low reset
//   ps2_clk, ps2_dat  raw asynchronous PS/2 lines
//   row_sel           PPI port A, bit r low selects row r
//   col_n             PPI port B, bit c low when a selected row has key c pressed
//   mod_n             PPI port C[7:5], active-low {RUS, US, SS}
//   code, code_stb    last received byte and its one-cycle update strobe
//   err               one-cycle pulse on parity or stop-bit error
module ps2_matrix_kbd #(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 4000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    input  logic [7:0] row_sel,
    output logic [7:0] col_n,
    output logic [2:0] mod_n,
    output logic [7:0] code,
    output logic       code_stb,
    output logic       err
);

    localparam int FW = $clog2(FILTER + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // Modifier flag indices; the two shifts are kept apart so releasing one
    // while the other is held keeps SS asserted.
    localparam int M_LSHIFT = 0;
    localparam int M_RSHIFT = 1;
    localparam int M_CTRL   = 2;
    localparam int M_RUS    = 3;

    // ---------------- input synchronizers and clock filter ----------------
    logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic          filt_q, filt_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          fall_q, fall_d;
    logic          bit_q, bit_d;

    always_comb begin
        clk_s1_d   = ps2_clk;
        clk_s2_d   = clk_s1_q;
        dat_s1_d   = ps2_dat;
        dat_s2_d   = dat_s1_q;
        filt_d     = filt_q;
        filt_cnt_d = '0;
        // Count consecutive samples that disagree with the filtered level;
        // the FILTER-th one flips it, any agreeing sample restarts the count.
        if (clk_s2_q != filt_q) begin
            if (filt_cnt_q == FW'(FILTER - 1)) begin
                filt_d = clk_s2_q;
            end else begin
                filt_cnt_d = filt_cnt_q + FW'(1);
            end
        end
        fall_d = filt_q & ~filt_d;
        bit_d  = dat_s2_q;
    end

    // ---------------- receiver FSM ----------------
    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    code_q, code_d;
    logic          code_stb_q, code_stb_d;
    logic          err_q, err_d;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        code_d     = code_q;
        code_stb_d = 1'b0;
        err_d      = 1'b0;

        if (fall_q || state_q == IDLE) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end

        case (state_q)
            IDLE: begin
                if (fall_q && !bit_q) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            DATA: begin
                if (fall_q) begin
                    shreg_d   = {bit_q, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall_q) begin
                    par_d   = bit_q;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (fall_q) begin
                    if (bit_q && (^{par_q, shreg_q})) begin
                        code_d     = shreg_q;
                        code_stb_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abandoned frame: drop silently, no error pulse.
        if (state_q != IDLE && !fall_q && tmo_q >= TW'(TIMEOUT - 1)) begin
            state_d = IDLE;
            tmo_d   = '0;
        end
    end

    // ---------------- scan-code decoder ----------------
    logic [2:0]      skip_q, skip_d;
    logic            brk_q, brk_d;
    logic            ext_q, ext_d;
    logic [7:0][7:0] matrix_q, matrix_d;   // matrix_q[row][col]
    logic [3:0]      mods_q, mods_d;

    logic            hit_mat, hit_mod;
    logic [2:0]      lk_row, lk_col;
    logic [1:0]      lk_mod;

    // Layout lookup keyed by {ext, byte}.
    always_comb begin
        hit_mat = 1'b0;
        hit_mod = 1'b0;
        lk_row  = 3'd0;
        lk_col  = 3'd0;
        lk_mod  = 2'd0;
        case ({ext_q, code_q})
            9'h01C: begin hit_mat = 1'b1; lk_row = 3'd4; lk_col = 3'd1; end  // A
            9'h05A: begin hit_mat = 1'b1; lk_row = 3'd0; lk_col = 3'd2; end  // Enter
            9'h029: begin hit_mat = 1'b1; lk_row = 3'd7; lk_col = 3'd7; end  // Space
            9'h175: begin hit_mat = 1'b1; lk_row = 3'd0; lk_col = 3'd5; end  // Up
            9'h012: begin hit_mod = 1'b1; lk_mod = 2'(M_LSHIFT); end
            9'h059: begin hit_mod = 1'b1; lk_mod = 2'(M_RSHIFT); end
            9'h014: begin hit_mod = 1'b1; lk_mod = 2'(M_CTRL); end
            9'h114: begin hit_mod = 1'b1; lk_mod = 2'(M_CTRL); end
            9'h058: begin hit_mod = 1'b1; lk_mod = 2'(M_RUS); end
            default: ;
        endcase
    end

    always_comb begin
        skip_d   = skip_q;
        brk_d    = brk_q;
        ext_d    = ext_q;
        matrix_d = matrix_q;
        mods_d   = mods_q;
        if (code_stb_q) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 3'd1;
            end else if (code_q == 8'hE1) begin
                // Pause sends E1 plus 7 more bytes that map to nothing.
                skip_d = 3'd7;
            end else if (code_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (code_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (code_q == 8'hAA) begin
                // Self-test pass after keyboard power-up: nothing is held.
                matrix_d = '0;
                mods_d   = '0;
                brk_d    = 1'b0;
                ext_d    = 1'b0;
            end else if (code_q == 8'hFA || code_q == 8'hEE || code_q == 8'hFE ||
                         code_q == 8'h00 || code_q == 8'hFF) begin
                brk_d = 1'b0;
                ext_d = 1'b0;
            end else begin
                if (hit_mat) begin
                    matrix_d[lk_row][lk_col] = ~brk_q;
                end
                if (hit_mod) begin
                    mods_d[lk_mod] = ~brk_q;
                end
                brk_d = 1'b0;
                ext_d = 1'b0;
            end
        end
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
            fall_q     <= 1'b0;
            bit_q      <= 1'b1;
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            shreg_q    <= 8'h00;
            par_q      <= 1'b0;
            tmo_q      <= '0;
            code_q     <= 8'h00;
            code_stb_q <= 1'b0;
            err_q      <= 1'b0;
            skip_q     <= 3'd0;
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
            matrix_q   <= '0;
            mods_q     <= 4'h0;
        end else begin
            clk_s1_q   <= clk_s1_d;
            clk_s2_q   <= clk_s2_d;
            dat_s1_q   <= dat_s1_d;
            dat_s2_q   <= dat_s2_d;
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
            fall_q     <= fall_d;
            bit_q      <= bit_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
            code_q     <= code_d;
            code_stb_q <= code_stb_d;
            err_q      <= err_d;
            skip_q     <= skip_d;
            brk_q      <= brk_d;
            ext_q      <= ext_d;
            matrix_q   <= matrix_d;
            mods_q     <= mods_d;
        end
    end

    // ---------------- outputs ----------------
    // The PPI samples port B without reference to clk, so the column read
    // stays combinational from row_sel.
    always_comb begin
        col_n = 8'hFF;
        for (int r = 0; r < 8; r++) begin
            if (!row_sel[r]) begin
                col_n = col_n & ~matrix_q[r];
            end
        end
    end

    assign mod_n    = ~{mods_q[M_RUS], mods_q[M_CTRL], mods_q[M_LSHIFT] | mods_q[M_RSHIFT]};
    assign code     = code_q;
    assign code_stb = code_stb_q;
    assign err      = err_q;

endmodule

// File: tb/tb_ps2_matrix_kbd.sv
// Directed bench for ps2_matrix_kbd: drives PS/2 frames bit by bit and checks matrix/modifier reads.
// Latency: frames are slow (40 clk per bit), results are checked after each frame completes.
// Backpressure: none; the bench free-runs the PS/2 clock.
module tb_ps2_matrix_kbd;

    logic       clk;
    logic       reset_n;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] row_sel;
    logic [7:0] col_n;
    logic [2:0] mod_n;
    logic [7:0] code;
    logic       code_stb;
    logic       err;

    int total = 0;
    int bad   = 0;

    int         stb_cnt = 0;
    int         err_cnt = 0;
    logic [7:0] col_at_stb    = 8'h00;
    logic [7:0] col_after_stb = 8'h00;
    logic       stb_d         = 1'b0;
    int         s0, e0;

    ps2_matrix_kbd #(.FILTER(8), .TIMEOUT(4000)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .ps2_clk  (ps2_clk),
        .ps2_dat  (ps2_dat),
        .row_sel  (row_sel),
        .col_n    (col_n),
        .mod_n    (mod_n),
        .code     (code),
        .code_stb (code_stb),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor: col_at_stb is col_n in the strobe cycle (T+1),
    // col_after_stb is col_n one cycle later (T+2).
    always @(negedge clk) begin
        if (stb_d) col_after_stb = col_n;
        if (code_stb) begin
            col_at_stb = col_n;
            stb_cnt++;
        end
        if (err) err_cnt++;
        stb_d = code_stb;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_dat = b;
        cycles(10);
        ps2_clk = 1'b0;
        cycles(20);
        ps2_clk = 1'b1;
        cycles(10);
    endtask

    task automatic send_byte(input logic [7:0] data, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(data[i]);
        ps2_bit((~^data) ^ bad_par);
        ps2_bit(1'b1);
        ps2_dat = 1'b1;
        cycles(20);
    endtask

    initial begin
        reset_n = 1'b0;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        row_sel = 8'h00;
        cycles(5);

        // Reset state with every row selected.
        check("rst_col_n", col_n, 8'hFF);
        check("rst_mod_n", mod_n, 3'h7);
        check("rst_code", code, 8'h00);
        check("rst_stb", code_stb, 1'b0);
        check("rst_err", err, 1'b0);
        reset_n = 1'b1;
        row_sel = 8'hFF;
        cycles(5);

        // Press A.
        s0 = stb_cnt;
        send_byte(8'h1C, 1'b0);
        check("a_stb_cnt", stb_cnt - s0, 1);
        check("a_code", code, 8'h1C);
        row_sel = 8'hEF; #2;
        check("a_row4", col_n, 8'hFD);
        row_sel = 8'hFF; #2;
        check("a_none", col_n, 8'hFF);

        // Release A with row 4 selected; cell clears exactly at T+2.
        row_sel = 8'hEF;
        s0 = stb_cnt;
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b0);
        check("rel_stb_cnt", stb_cnt - s0, 2);
        check("rel_col_t1", col_at_stb, 8'hFD);
        check("rel_col_t2", col_after_stb, 8'hFF);
        check("rel_col_now", col_n, 8'hFF);

        // Extended Up, then shifts.
        send_byte(8'hE0, 1'b0);
        send_byte(8'h75, 1'b0);
        row_sel = 8'hFE; #2;
        check("up_row0", col_n, 8'hDF);
        row_sel = 8'hEF; #2;
        check("up_row4", col_n, 8'hFF);
        send_byte(8'h12, 1'b0);
        check("lshift_mod", mod_n, 3'h6);
        send_byte(8'h59, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h12, 1'b0);
        check("rshift_held_mod", mod_n, 3'h6);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h59, 1'b0);
        check("shift_off_mod", mod_n, 3'h7);

        // Ctrl via extended code and CapsLock.
        send_byte(8'hE0, 1'b0);
        send_byte(8'h14, 1'b0);
        send_byte(8'h58, 1'b0);
        check("ctrl_rus_mod", mod_n, 3'h1);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h14, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h58, 1'b0);
        check("ctrl_rus_off", mod_n, 3'h7);

        // Release Up (E0 F0 75).
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h75, 1'b0);
        row_sel = 8'hFE; #2;
        check("up_rel", col_n, 8'hFF);

        // Parity error on 1C.
        s0 = stb_cnt; e0 = err_cnt;
        send_byte(8'h1C, 1'b1);
        check("par_err_cnt", err_cnt - e0, 1);
        check("par_stb_cnt", stb_cnt - s0, 0);
        row_sel = 8'hEF; #2;
        check("par_matrix", col_n, 8'hFF);
        send_byte(8'h5A, 1'b0);
        check("enter_code", code, 8'h5A);
        row_sel = 8'hFE; #2;
        check("enter_row0", col_n, 8'hFB);

        // Timeout: five bit slots then silence.
        s0 = stb_cnt; e0 = err_cnt;
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        cycles(4010);
        send_byte(8'h29, 1'b0);
        check("tmo_code", code, 8'h29);
        check("tmo_err_cnt", err_cnt - e0, 0);
        check("tmo_stb_cnt", stb_cnt - s0, 1);
        row_sel = 8'h7F; #2;
        check("space_row7", col_n, 8'h7F);

        // Reset mid-frame with keys held.
        send_byte(8'h1C, 1'b0);
        send_byte(8'h12, 1'b0);
        row_sel = 8'hEF; #2;
        check("hold_a", col_n, 8'hFD);
        check("hold_shift", mod_n, 3'h6);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_dat = 1'b0;
        cycles(10);
        ps2_clk = 1'b0;
        cycles(5);
        reset_n = 1'b0;
        row_sel = 8'h00;
        #2;
        check("midrst_col_n", col_n, 8'hFF);
        check("midrst_mod_n", mod_n, 3'h7);
        check("midrst_code", code, 8'h00);
        cycles(3);
        reset_n = 1'b1;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        cycles(30);

        // Three-cycle clock glitch with data low must not start a frame.
        s0 = stb_cnt; e0 = err_cnt;
        ps2_dat = 1'b0;
        cycles(2);
        ps2_clk = 1'b0;
        cycles(3);
        ps2_clk = 1'b1;
        cycles(5);
        ps2_dat = 1'b1;
        cycles(20);
        send_byte(8'h5A, 1'b0);
        check("glitch_code", code, 8'h5A);
        check("glitch_err_cnt", err_cnt - e0, 0);
        check("glitch_stb_cnt", stb_cnt - s0, 1);
        row_sel = 8'hFE; #2;
        check("glitch_row0", col_n, 8'hFB);
        row_sel = 8'hEF; #2;
        check("glitch_row4", col_n, 8'hFF);

        // BAT clears everything.
        send_byte(8'h29, 1'b0);
        send_byte(8'h58, 1'b0);
        send_byte(8'hAA, 1'b0);
        row_sel = 8'h00; #2;
        check("bat_col_n", col_n, 8'hFF);
        check("bat_mod_n", mod_n, 3'h7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
